// File: rtl/seg_pkg.sv
// Shared segment codes and types for the seven-segment display path.
// Segment bit order: bit0=a ... bit6=g, active high.
package seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_encode.sv
// Combinational BCD to seven-segment encoder; non-BCD values show a dash.
module seg_encode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner over NDIG snapshot BCD digits.
// Optional blinking is built only when SCAN_BLINK_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NDIG         = 6,
  parameter int PRESCALE     = 4,
  parameter int BLINK_FRAMES = 2
)(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic [4*NDIG-1:0] Digits,
  input  logic              Blank_lz,
  input  logic              Blink,
  output logic [6:0]        Seg_out,
  output logic [NDIG-1:0]   Dig_en,
  output logic [2:0]        Dig_idx,
  output logic              Frame_start
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [2:0]     IDX_LAST = 3'(NDIG - 1);
  localparam logic [NDIG-1:0] ONE_HOT0 = NDIG'(1);

  scan_state_t       state_q, state_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [4*NDIG-1:0] snap_q, snap_d;
  seg_t              seg_q, seg_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;
  logic              frame_q, frame_d;

  logic              active;
  logic              wrap;
  logic              lz_blank;
  logic              blink_off;
  logic [3:0]        cur_digit;
  seg_t              cur_seg;

  // The digit about to be driven is taken from the next snapshot so that
  // frame entry and wrap display the freshly captured value.
  assign cur_digit = snap_d[4*int'(idx_d) +: 4];

  seg_encode u_enc (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
    active  = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d = ST_SCAN;
          snap_d  = Digits;
          idx_d   = 3'd0;
          pre_d   = '0;
          frame_d = 1'b1;
          active  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!Enable) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          pre_d   = '0;
        end else begin
          active = 1'b1;
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = 3'd0;
              snap_d  = Digits;
              frame_d = 1'b1;
              wrap    = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SCAN_BLINK_EN
  localparam int            BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_FRAMES - 1);

  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (!active) begin
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (wrap) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign blink_off = Blink & phase_d;
`else
  logic blink_unused;
  assign blink_unused = Blink | wrap;
  assign blink_off    = 1'b0;
`endif

  assign lz_blank = Blank_lz && (idx_d == IDX_LAST) && (cur_digit == 4'd0);

  always_comb begin
    dig_en_d = '0;
    seg_d    = SEG_BLANK;
    if (active) begin
      dig_en_d = ONE_HOT0 << idx_d;
      if (!lz_blank && !blink_off) begin
        seg_d = cur_seg;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      idx_q    <= 3'd0;
      snap_q   <= '0;
      seg_q    <= SEG_BLANK;
      dig_en_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
      frame_q  <= frame_d;
    end
  end

  assign Seg_out     = seg_q;
  assign Dig_en      = dig_en_q;
  assign Dig_idx     = idx_q;
  assign Frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux (NDIG=6, PRESCALE=4).
module tb_seg_scan_mux;

  logic        Clk;
  logic        Reset_n;
  logic        Enable;
  logic [23:0] Digits;
  logic        Blank_lz;
  logic        Blink;
  logic [6:0]  Seg_out;
  logic [5:0]  Dig_en;
  logic [2:0]  Dig_idx;
  logic        Frame_start;

  int checks   = 0;
  int failures = 0;

  seg_scan_mux #(.NDIG(6), .PRESCALE(4), .BLINK_FRAMES(2)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Enable      (Enable),
    .Digits      (Digits),
    .Blank_lz    (Blank_lz),
    .Blink       (Blink),
    .Seg_out     (Seg_out),
    .Dig_en      (Dig_en),
    .Dig_idx     (Dig_idx),
    .Frame_start (Frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] seg, input logic [5:0] en,
                         input logic [2:0] idx, input logic fs);
    chk({tag, "_seg"}, 24'(Seg_out), 24'(seg));
    chk({tag, "_en"}, 24'(Dig_en), 24'(en));
    chk({tag, "_idx"}, 24'(Dig_idx), 24'(idx));
    chk({tag, "_fs"}, 24'(Frame_start), 24'(fs));
  endtask

  logic [6:0] blink_seg0;
  logic [6:0] blink_seg1;

  initial begin
`ifdef SCAN_BLINK_EN
    blink_seg0 = 7'h00;
    blink_seg1 = 7'h00;
`else
    blink_seg0 = 7'h7D;
    blink_seg1 = 7'h6D;
`endif
    Reset_n  = 1'b0;
    Enable   = 1'b0;
    Digits   = 24'h0;
    Blank_lz = 1'b0;
    Blink    = 1'b0;
    adv(3);
    chk_all("reset", 7'h00, 6'b000000, 3'd0, 1'b0);
    Reset_n = 1'b1;
    adv(3);
    chk_all("post_reset_idle", 7'h00, 6'b000000, 3'd0, 1'b0);

    // 12:34:56 -> digit0..5 = 6,5,4,3,2,1
    Digits = 24'h123456;
    Enable = 1'b1;
    adv(1);
    chk_all("f0_d0", 7'h7D, 6'b000001, 3'd0, 1'b1);
    adv(1);
    chk_all("f0_d0_hold", 7'h7D, 6'b000001, 3'd0, 1'b0);
    adv(3);
    chk_all("f0_d1", 7'h6D, 6'b000010, 3'd1, 1'b0);
    adv(4);
    chk_all("f0_d2", 7'h66, 6'b000100, 3'd2, 1'b0);
    Digits   = 24'h080000;
    Blank_lz = 1'b1;
    adv(4);
    chk_all("f0_d3_old", 7'h4F, 6'b001000, 3'd3, 1'b0);
    adv(4);
    chk_all("f0_d4_old", 7'h5B, 6'b010000, 3'd4, 1'b0);
    adv(4);
    chk_all("f0_d5_old", 7'h06, 6'b100000, 3'd5, 1'b0);
    adv(3);
    chk("f0_last_fs", 24'(Frame_start), 24'h0);
    adv(1);
    chk_all("f1_d0", 7'h3F, 6'b000001, 3'd0, 1'b1);
    adv(16);
    chk_all("f1_d4", 7'h7F, 6'b010000, 3'd4, 1'b0);
    adv(4);
    chk_all("f1_d5_lz", 7'h00, 6'b100000, 3'd5, 1'b0);

    Digits = 24'h000B00;
    adv(4);
    chk_all("f2_d0", 7'h3F, 6'b000001, 3'd0, 1'b1);
    adv(8);
    chk_all("f2_d2_dash", 7'h40, 6'b000100, 3'd2, 1'b0);
    adv(4);
    chk_all("f2_d3", 7'h3F, 6'b001000, 3'd3, 1'b0);
    adv(1);
    Enable = 1'b0;
    adv(1);
    chk_all("disable", 7'h00, 6'b000000, 3'd0, 1'b0);
    adv(2);
    chk_all("disable_hold", 7'h00, 6'b000000, 3'd0, 1'b0);

    Digits = 24'h000009;
    Enable = 1'b1;
    adv(1);
    chk_all("reenable", 7'h6F, 6'b000001, 3'd0, 1'b1);

    Blink    = 1'b1;
    Blank_lz = 1'b0;
    Digits   = 24'h123456;
    adv(28);
    chk_all("blink_fr1_d1", 7'h6D, 6'b000010, 3'd1, 1'b0);
    adv(20);
    chk_all("blink_fr2_d0", blink_seg0, 6'b000001, 3'd0, 1'b1);
    adv(28);
    chk_all("blink_fr3_d1", blink_seg1, 6'b000010, 3'd1, 1'b0);
    adv(20);
    chk_all("blink_fr4_d0", 7'h7D, 6'b000001, 3'd0, 1'b1);

    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("async_reset", 7'h00, 6'b000000, 3'd0, 1'b0);
    Enable = 1'b0;
    adv(2);
    Reset_n = 1'b1;
    adv(2);
    chk_all("after_reset_idle", 7'h00, 6'b000000, 3'd0, 1'b0);
    Digits = 24'h000000;
    Blink  = 1'b0;
    Enable = 1'b1;
    adv(1);
    chk_all("after_reset_start", 7'h3F, 6'b000001, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
